// File: rtl/trap_ctrl_pkg.sv
// Shared types for the machine-mode trap sequencer: cause codes, MEPC source select,
// privilege levels, MIE bit positions and the sequencer state encoding.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } privilege_e;

    // {interrupt, code[4:0]}; MCAUSE_NONE is what the bus carries while the strobe is low
    typedef enum logic [5:0] {
        MCAUSE_NONE    = 6'h00,
        EXC_ILLEGAL    = 6'h02,
        EXC_BREAKPOINT = 6'h03,
        EXC_ECALL_U    = 6'h08,
        EXC_ECALL_M    = 6'h0B,
        INT_MSI        = 6'h23,
        INT_MTI        = 6'h27,
        INT_MEI        = 6'h2B
    } mcause_e;

    typedef enum logic {
        MEPC_PC_WB = 1'b0,
        MEPC_PC_IF = 1'b1
    } mepc_mux_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    // Interrupt sources listed highest priority first
    localparam int      NUM_IRQ = 3;
    localparam int      IRQ_BIT   [NUM_IRQ] = '{MIE_MEIE, MIE_MSIE, MIE_MTIE};
    localparam mcause_e IRQ_CAUSE [NUM_IRQ] = '{INT_MEI, INT_MSI, INT_MTI};

    function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
        return {mtvec[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Fetch redirect handshake between the trap sequencer (master) and the fetch unit (slave).
interface trap_ctrl_if;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/trap_prio_enc.sv
// Combinational classifier: picks the winning synchronous exception, flags a legal MRET,
// and picks the highest-priority enabled interrupt.
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic               wb_valid,
    input  logic               wb_illegal,
    input  logic               wb_ecall,
    input  logic               wb_ebreak,
    input  logic               wb_mret,
    input  privilege_e         privilege_mode,
    input  logic               mstatus_mie,
    input  logic [NUM_IRQ-1:0] irq_line,
    input  logic [NUM_IRQ-1:0] irq_enable,
    output logic               exc_valid,
    output mcause_e            exc_cause,
    output logic               mret_valid,
    output logic               irq_valid,
    output mcause_e            irq_cause
);

    logic               user_mode;
    logic               illegal_ev;
    logic               global_en;
    logic [NUM_IRQ-1:0] irq_pend;

    assign user_mode  = (privilege_mode == PRIV_U);
    // MRET from user mode is an illegal instruction, not a return
    assign illegal_ev = wb_illegal | (wb_mret & user_mode);
    assign exc_valid  = wb_valid & (illegal_ev | wb_ecall | wb_ebreak);
    assign mret_valid = wb_valid & wb_mret & (privilege_mode == PRIV_M) & ~exc_valid;

    always_comb begin
        exc_cause = MCAUSE_NONE;
        if (illegal_ev)
            exc_cause = EXC_ILLEGAL;
        else if (wb_ecall)
            exc_cause = user_mode ? EXC_ECALL_U : EXC_ECALL_M;
        else if (wb_ebreak)
            exc_cause = EXC_BREAKPOINT;
    end

    // Lower privilege is always interruptible regardless of MIE
    assign global_en = user_mode | mstatus_mie;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
            assign irq_pend[gi] = irq_line[gi] & irq_enable[gi] & global_en;
        end
    endgenerate

    assign irq_valid = |irq_pend;

    always_comb begin
        irq_cause = MCAUSE_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i])
                irq_cause = IRQ_CAUSE[i];
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains for interrupts, emits CSR strobes, flushes and redirects fetch.
// Build option: TRAP_VECTORED_EN enables vectored interrupt targets (mtvec[1:0]==1).
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic               wb_illegal,
    input  logic               wb_ecall,
    input  logic               wb_ebreak,
    input  logic               wb_mret,
    input  logic               pipe_empty,
    input  logic               extern_intr,
    input  logic               timer_intr,
    input  logic               software_intr,
    input  privilege_e         privilege_mode,
    input  logic               mstatus_mie,
    input  logic [31:0]        mie,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc,
    output logic               hold_fetch,
    output logic               flush,
    trap_ctrl_if.master        redir,
    output logic               mcause_update,
    output mcause_e            mcause,
    output logic               mepc_updata,
    output mepc_mux_e          mepc_mux,
    output logic               is_mret
);

    trap_state_e        state_reg, state_next;
    logic [31:0]        redirect_pc_reg;
    logic [NUM_IRQ-1:0] irq_line;
    logic [NUM_IRQ-1:0] irq_enable;
    logic               exc_valid, mret_valid, irq_valid;
    mcause_e            exc_cause, irq_cause;
    logic               trap_fire, mret_fire, trap_is_irq;
    mcause_e            trap_cause;
    mepc_mux_e          mepc_sel;
    logic [31:0]        trap_target;
    logic               unused_mie;

    // Line order matches IRQ_BIT/IRQ_CAUSE: MEI, MSI, MTI
    assign irq_line = {timer_intr, software_intr, extern_intr};

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_mie
            assign irq_enable[gi] = mie[IRQ_BIT[gi]];
        end
    endgenerate

    assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

    trap_prio_enc u_prio (
        .wb_valid       (wb_valid),
        .wb_illegal     (wb_illegal),
        .wb_ecall       (wb_ecall),
        .wb_ebreak      (wb_ebreak),
        .wb_mret        (wb_mret),
        .privilege_mode (privilege_mode),
        .mstatus_mie    (mstatus_mie),
        .irq_line       (irq_line),
        .irq_enable     (irq_enable),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .mret_valid     (mret_valid),
        .irq_valid      (irq_valid),
        .irq_cause      (irq_cause)
    );

    always_comb begin
        state_next  = state_reg;
        trap_fire   = 1'b0;
        mret_fire   = 1'b0;
        trap_is_irq = 1'b0;
        trap_cause  = MCAUSE_NONE;
        mepc_sel    = MEPC_PC_WB;
        // Events seen while reset is asserted are dropped, so no strobe escapes a reset
        if (!reset) begin
            case (state_reg)
                ST_IDLE, ST_DRAIN: begin
                    if (exc_valid) begin
                        trap_fire  = 1'b1;
                        trap_cause = exc_cause;
                        state_next = ST_REDIRECT;
                    end else if (mret_valid) begin
                        mret_fire  = 1'b1;
                        state_next = ST_REDIRECT;
                    end else if (state_reg == ST_IDLE) begin
                        if (irq_valid)
                            state_next = ST_DRAIN;
                    end else if (!irq_valid) begin
                        state_next = ST_IDLE;
                    end else if (pipe_empty) begin
                        trap_fire   = 1'b1;
                        trap_is_irq = 1'b1;
                        trap_cause  = irq_cause;
                        mepc_sel    = MEPC_PC_IF;
                        state_next  = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redir.redirect_ready)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = trap_base(mtvec);
        if (trap_is_irq && (mtvec[1:0] == 2'b01))
            trap_target = trap_base(mtvec) + {25'd0, trap_cause[4:0], 2'b00};
    end
`else
    logic unused_vec;
    assign trap_target = trap_base(mtvec);
    assign unused_vec  = ^{mtvec[1:0], trap_is_irq};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            redirect_pc_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (trap_fire)
                redirect_pc_reg <= trap_target;
            else if (mret_fire)
                redirect_pc_reg <= mepc;
        end
    end

    assign hold_fetch           = (state_reg == ST_DRAIN);
    assign redir.redirect_valid = (state_reg == ST_REDIRECT);
    assign redir.redirect_pc    = redirect_pc_reg;
    assign flush                = trap_fire | mret_fire;
    assign mcause_update        = trap_fire;
    assign mepc_updata          = trap_fire;
    assign mcause               = trap_fire ? trap_cause : MCAUSE_NONE;
    assign mepc_mux             = trap_fire ? mepc_sel : MEPC_PC_WB;
    assign is_mret              = mret_fire;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a per-cycle reference model plus hand-computed spot checks.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

`ifdef TRAP_VECTORED_EN
    localparam bit VECT = 1'b1;
`else
    localparam bit VECT = 1'b0;
`endif
    localparam logic [31:0] EXP_MTI_PC = VECT ? 32'h8000_001C : 32'h8000_0000;
    localparam logic [31:0] EXP_MEI_PC = VECT ? 32'h8000_002C : 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_illegal, wb_ecall, wb_ebreak, wb_mret, pipe_empty;
    logic        extern_intr, timer_intr, software_intr, mstatus_mie;
    privilege_e  privilege_mode;
    logic [31:0] mie, mtvec, mepc;
    logic        hold_fetch, flush, mcause_update, mepc_updata, is_mret;
    mcause_e     mcause;
    mepc_mux_e   mepc_mux;

    trap_ctrl_if redir_if ();

    trap_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_illegal     (wb_illegal),
        .wb_ecall       (wb_ecall),
        .wb_ebreak      (wb_ebreak),
        .wb_mret        (wb_mret),
        .pipe_empty     (pipe_empty),
        .extern_intr    (extern_intr),
        .timer_intr     (timer_intr),
        .software_intr  (software_intr),
        .privilege_mode (privilege_mode),
        .mstatus_mie    (mstatus_mie),
        .mie            (mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .hold_fetch     (hold_fetch),
        .flush          (flush),
        .redir          (redir_if),
        .mcause_update  (mcause_update),
        .mcause         (mcause),
        .mepc_updata    (mepc_updata),
        .mepc_mux       (mepc_mux),
        .is_mret        (is_mret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the sequencer owes, derived from the trap rules
    bit          m_drain = 1'b0;
    bit          m_redir = 1'b0;
    logic [31:0] m_pc    = 32'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          user, exc, mret_ev, irq_on, e_fire, e_mret, e_pcif;
            int          exc_code, irq_code, e_cause;
            logic [31:0] tgt;
            user     = (privilege_mode == PRIV_U);
            exc      = wb_valid && (wb_illegal || wb_ecall || wb_ebreak || (wb_mret && user));
            exc_code = (wb_illegal || (wb_mret && user)) ? 2 : (wb_ecall ? (user ? 8 : 11) : 3);
            mret_ev  = wb_valid && wb_mret && (privilege_mode == PRIV_M) && !exc;
            irq_code = 0;
            if (user || mstatus_mie) begin
                if (timer_intr && mie[7])     irq_code = 32 + 7;
                if (software_intr && mie[3])  irq_code = 32 + 3;
                if (extern_intr && mie[11])   irq_code = 32 + 11;
            end
            irq_on = (irq_code != 0);

            e_fire = 1'b0; e_mret = 1'b0; e_pcif = 1'b0; e_cause = 0;
            if (!reset && !m_redir) begin
                if (exc) begin
                    e_fire = 1'b1; e_cause = exc_code;
                end else if (mret_ev) begin
                    e_mret = 1'b1;
                end else if (m_drain && irq_on && pipe_empty) begin
                    e_fire = 1'b1; e_cause = irq_code; e_pcif = 1'b1;
                end
            end

            chk("hold_fetch",     {31'd0, hold_fetch},              {31'd0, m_drain});
            chk("redirect_valid", {31'd0, redir_if.redirect_valid}, {31'd0, m_redir});
            chk("redirect_pc",    redir_if.redirect_pc,             m_pc);
            chk("mcause_update",  {31'd0, mcause_update},           {31'd0, e_fire});
            chk("mepc_updata",    {31'd0, mepc_updata},             {31'd0, e_fire});
            chk("mcause",         32'(mcause),                      32'(e_cause));
            chk("mepc_mux",       32'(mepc_mux),                    {31'd0, e_pcif});
            chk("is_mret",        {31'd0, is_mret},                 {31'd0, e_mret});
            chk("flush",          {31'd0, flush},                   {31'd0, e_fire | e_mret});

            tgt = mtvec & 32'hFFFF_FFFC;
            if (VECT && e_cause >= 32 && mtvec[1:0] == 2'b01)
                tgt = tgt + 32'((e_cause - 32) * 4);

            if (reset) begin
                m_drain = 1'b0; m_redir = 1'b0; m_pc = 32'd0;
            end else if (m_redir) begin
                if (redir_if.redirect_ready) m_redir = 1'b0;
            end else if (e_fire || e_mret) begin
                m_redir = 1'b1; m_drain = 1'b0;
                m_pc    = e_mret ? mepc : tgt;
            end else begin
                m_drain = irq_on;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_illegal = 0; wb_ecall = 0; wb_ebreak = 0; wb_mret = 0;
    endtask

    initial begin
        reset = 1; clear_wb(); pipe_empty = 0;
        extern_intr = 0; timer_intr = 0; software_intr = 0; mstatus_mie = 0;
        privilege_mode = PRIV_M; mie = 0; mtvec = 0; mepc = 0;
        redir_if.redirect_ready = 0;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_redirect_pc", redir_if.redirect_pc, 32'h0);
        chk("rst_mcause",      32'(mcause),          32'h0);
        chk("rst_mepc_mux",    32'(mepc_mux),        32'(MEPC_PC_WB));
        tick();
        reset = 0;
        @(negedge clk); tick();

        // Illegal instruction in U mode
        privilege_mode = PRIV_U; mtvec = 32'h8000_0100; wb_valid = 1; wb_illegal = 1;
        @(negedge clk);
        chk("t1_mcause",   32'(mcause),   32'h02);
        chk("t1_mepc_mux", 32'(mepc_mux), 32'(MEPC_PC_WB));
        chk("t1_flush",    {31'd0, flush}, 32'd1);
        tick();
        clear_wb(); redir_if.redirect_ready = 1;
        @(negedge clk);
        chk("t1_rvalid", {31'd0, redir_if.redirect_valid}, 32'd1);
        chk("t1_rpc",    redir_if.redirect_pc, 32'h8000_0100);
        $display("txn illegal_u: redirect_pc=0x%08h", redir_if.redirect_pc);
        tick();

        // Vectored timer interrupt after a 3-cycle drain
        redir_if.redirect_ready = 0;
        privilege_mode = PRIV_M; mtvec = 32'h8000_0001; mie = 32'h80; mstatus_mie = 1; timer_intr = 1;
        @(negedge clk); chk("t2_hold_idle", {31'd0, hold_fetch}, 32'd0); tick();
        @(negedge clk); chk("t2_hold1", {31'd0, hold_fetch}, 32'd1); tick();
        @(negedge clk); chk("t2_hold2", {31'd0, hold_fetch}, 32'd1); tick();
        pipe_empty = 1;
        @(negedge clk);
        chk("t2_mcause",   32'(mcause),   32'h27);
        chk("t2_mepc_mux", 32'(mepc_mux), 32'(MEPC_PC_IF));
        tick();
        timer_intr = 0; pipe_empty = 0; redir_if.redirect_ready = 1;
        @(negedge clk);
        chk("t2_rpc", redir_if.redirect_pc, EXP_MTI_PC);
        $display("txn timer_irq: redirect_pc=0x%08h", redir_if.redirect_pc);
        tick();

        // External interrupt withdrawn while draining
        redir_if.redirect_ready = 0; mie = 32'h800; extern_intr = 1;
        @(negedge clk); tick();
        extern_intr = 0;
        @(negedge clk);
        chk("t3_hold_drain", {31'd0, hold_fetch},    32'd1);
        chk("t3_no_strobe",  {31'd0, mcause_update}, 32'd0);
        tick();
        @(negedge clk);
        chk("t3_hold_after", {31'd0, hold_fetch}, 32'd0);
        $display("txn irq_withdrawn: hold_fetch=%0b", hold_fetch);
        tick();

        // MRET in M mode, then in U mode
        mie = 0; mepc = 32'h0000_2000; wb_valid = 1; wb_mret = 1;
        @(negedge clk);
        chk("t4_is_mret", {31'd0, is_mret}, 32'd1);
        chk("t4_flush",   {31'd0, flush},   32'd1);
        tick();
        clear_wb(); redir_if.redirect_ready = 1;
        @(negedge clk);
        chk("t4_rpc", redir_if.redirect_pc, 32'h0000_2000);
        $display("txn mret_m: redirect_pc=0x%08h", redir_if.redirect_pc);
        tick();
        redir_if.redirect_ready = 0; privilege_mode = PRIV_U; wb_valid = 1; wb_mret = 1;
        @(negedge clk);
        chk("t4u_mcause",  32'(mcause),       32'h02);
        chk("t4u_is_mret", {31'd0, is_mret}, 32'd0);
        tick();
        clear_wb(); privilege_mode = PRIV_M; redir_if.redirect_ready = 1;
        @(negedge clk);
        chk("t4u_rpc", redir_if.redirect_pc, 32'h8000_0000);
        $display("txn mret_u: redirect_pc=0x%08h", redir_if.redirect_pc);
        tick();

        // ECALL from M mode together with MEI: exception first, interrupt afterwards
        redir_if.redirect_ready = 0; mie = 32'h800; extern_intr = 1; wb_valid = 1; wb_ecall = 1;
        @(negedge clk);
        chk("t5_mcause_exc", 32'(mcause), 32'h0B);
        tick();
        clear_wb(); redir_if.redirect_ready = 1; pipe_empty = 1;
        @(negedge clk); tick();
        redir_if.redirect_ready = 0;
        @(negedge clk); tick();
        @(negedge clk);
        chk("t5_mcause_irq", 32'(mcause), 32'h2B);
        $display("txn ecall_mei: mcause=0x%02h", 32'(mcause));
        tick();

        // Backpressure: 4 cycles without ready, with a WB exception that must be ignored
        extern_intr = 0; pipe_empty = 0; wb_valid = 1; wb_illegal = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_rpc_stable",  redir_if.redirect_pc, EXP_MEI_PC);
            chk("t6_no_strobe",   {31'd0, mcause_update}, 32'd0);
            tick();
        end
        clear_wb(); reset = 1;
        @(negedge clk); tick();
        reset = 0;
        @(negedge clk);
        chk("t6_rst_rvalid", {31'd0, redir_if.redirect_valid}, 32'd0);
        chk("t6_rst_rpc",    redir_if.redirect_pc, 32'h0);
        $display("txn backpressure_reset: redirect_valid=%0b", redir_if.redirect_valid);
        tick();
        @(negedge clk); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting between the writeback stage and the CSR block. It turns writeback exceptions, `mret`, and pending interrupts into the CSR update strobes: `mcause_update`, `mcause`, `mepc_updata`, `mepc_mux`, `is_mret`. It drains the pipeline before an interrupt is taken. It then flushes the pipeline and redirects fetch to the trap vector or to `mepc` through a valid/ready handshake.

## Interface
- No parameters.
- `clk` in 1 — core clock.
- `reset` in 1 — synchronous, active-high.
- `wb_valid` in 1 — WB holds a valid instruction.
- `wb_illegal` in 1 — illegal instruction or illegal CSR access at WB.
- `wb_ecall` in 1 — ECALL at WB.
- `wb_ebreak` in 1 — EBREAK at WB.
- `wb_mret` in 1 — MRET at WB.
- `pipe_empty` in 1 — ID/EX/WB hold no valid instruction.
- `extern_intr`, `timer_intr`, `software_intr` in 1 each — raw interrupt lines.
- `privilege_mode` in `privilege_e` — current privilege level.
- `mstatus_mie` in 1 — global machine interrupt enable.
- `mie` in 32 — interrupt enable CSR.
- `mtvec` in 32 — trap vector CSR.
- `mepc` in 32 — exception PC CSR.
- `hold_fetch` out 1 — stall IF during drain.
- `flush` out 1 — one-cycle kill of all stages.
- `redirect_valid` out 1, `redirect_ready` in 1, `redirect_pc` out 32 — fetch redirect handshake.
- `mcause_update` out 1, `mcause` out `mcause_e` — cause strobe and value.
- `mepc_updata` out 1, `mepc_mux` out `mepc_mux_e` — MEPC strobe and source select.
- `is_mret` out 1 — MRET strobe.

## Operation
- **FSM states:** IDLE, DRAIN, REDIRECT.
- **Exception event:** `wb_valid` & (`wb_illegal` | `wb_ecall` | `wb_ebreak` | (`wb_mret` & `privilege_mode`==U)).
  - Priority: illegal (cause 2) > ecall (8 from U, 11 from M) > ebreak (3).
  - MRET executed in U mode traps as illegal.
- **MRET event:** `wb_valid` & `wb_mret` & M mode, with no exception event.
- **Enabled interrupt:**
  - line & `mie` bit (MEIE 11, MSIE 3, MTIE 7) & (`privilege_mode`==U | `mstatus_mie`).
  - Priority: MEI (0x2B) > MSI (0x23) > MTI (0x27).
- **IDLE:**
  - Exception event → trap cycle: `mepc_mux`=PC_WB, → REDIRECT.
  - Else MRET event → `is_mret`=1, `flush`=1, `redirect_pc`←`mepc`, → REDIRECT.
  - Else enabled interrupt → DRAIN.
- **DRAIN:**
  - `hold_fetch`=1.
  - Exception or MRET event has priority: handled exactly as in IDLE.
  - Else interrupt no longer enabled → IDLE (`hold_fetch` drops next cycle).
  - Else `pipe_empty` → trap cycle with interrupt cause, `mepc_mux`=PC_IF, → REDIRECT.
- **Trap cycle (combinational, single cycle):**
  - `mcause_update`=1, `mepc_updata`=1, `flush`=1.
  - `mcause` = {interrupt bit, code[4:0]}.
  - `redirect_pc` registered.
- **Trap target:** base = {`mtvec[31:2]`, 2'b00}.
  - Interrupt with `mtvec[1:0]`==1: base + (code << 2), 32-bit wrap.
  - Otherwise: base.
- **REDIRECT:**
  - `redirect_valid`=1; `redirect_pc` held stable.
  - `redirect_valid` & `redirect_ready` → IDLE.
  - All events are ignored in this state.
- **Strobe gating:** strobes are zero in every cycle that is not a trap or MRET cycle. `mcause`/`mepc_mux` are don't-care while their strobe is low, but are driven to 0 / PC_WB.

## Timing
- **Reset:** state IDLE. All outputs 0: `redirect_pc`=0, `mcause`=0, `mepc_mux`=PC_WB.
- **Exception/MRET latency:** event at cycle T gives strobes and `flush` at T and `redirect_valid` from T+1.
- **Interrupt latency:** enabled at T0 → DRAIN at T0+1. The earliest trap is T0+1 when `pipe_empty`; `redirect_valid` follows at T0+2.
- **Handshake:** `redirect_valid` holds until accepted. `redirect_ready` asserted in the same cycle as `redirect_valid` rising completes the handshake in 1 cycle.
- **Reset mid-operation:** state → IDLE the next edge, and no pending strobe is emitted.
- **Simultaneous events:** a WB exception and an interrupt in the same cycle → exception wins; the interrupt is re-evaluated from IDLE after the redirect.

## Configuration
- **`TRAP_VECTORED_EN` defined:** vectored interrupt targets as specified above.
- **Not defined:** `mtvec[1:0]` is ignored and every trap targets base (direct mode only). The adder is removed.

## Structure
- **Shared package:**
  - `mcause_e` codes (EXC_ILLEGAL, EXC_BREAKPOINT, EXC_ECALL_U, EXC_ECALL_M, INT_MSI, INT_MTI, INT_MEI).
  - `mepc_mux_e` (MEPC_PC_IF, MEPC_PC_WB).
  - `privilege_e`.
  - MIE bit-index constants.
  - FSM state enum `trap_state_e`.
- **Sub-module:** `trap_prio_enc`, combinational, takes events/lines/enables and yields `valid` + `mcause_e`.

## Test plan
- **Illegal instruction in U mode:** `wb_valid`=1, `wb_illegal`=1, `mtvec`=0x8000_0100 → same cycle `mcause`=0x02, `mepc_mux`=PC_WB, `flush`=1. Next cycle `redirect_valid`=1, `redirect_pc`=0x8000_0100.
- **Vectored timer interrupt:** `mtvec`=0x8000_0001, `mie[7]`=1, `mstatus_mie`=1, M mode, `timer_intr`=1, `pipe_empty` asserted 3 cycles later → `hold_fetch` for 3 cycles, then `mcause`=0x27, `mepc_mux`=PC_IF, `redirect_pc`=0x8000_001C.
- **Interrupt withdrawn in DRAIN:** `extern_intr` drops before `pipe_empty` → return to IDLE with no strobes, and `hold_fetch` low the next cycle.
- **MRET in M mode:** `mepc`=0x0000_2000 → `is_mret`=1 for one cycle, `redirect_pc`=0x0000_2000. The same MRET in U mode instead gives `mcause`=0x02.
- **Simultaneous ECALL (M mode) and MEI:** → `mcause`=0x0B. The interrupt is taken after the handshake, with `mcause`=0x2B.
- **Backpressure:** `redirect_ready` low for 4 cycles → `redirect_valid` and `redirect_pc` stable and no new strobes. Assert `reset` mid-REDIRECT → all outputs 0 on the next cycle.
